// File: rtl/mult_pkg.sv
// Shared definitions for the systolic multiplier edge registers.
//
// Contents:
//   y_state_t  - state encoding of the result-capture register (y_reg)
//   MAX_STAGES - number of result words captured per run (pipeline depth)
//   IDX_W      - width of the absolute read index
//   PROD_W     - width of one product word (8x8 multiply)
//
// The constants are also used by the operand-side shift register, so
// keep both sides in step when changing them.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } y_state_t;

  localparam int MAX_STAGES = 8;
  localparam int IDX_W      = 5;
  localparam int PROD_W     = 16;

endpackage : mult_pkg

// File: rtl/y_reg.sv
// Result-capture register at the output edge of the systolic array.
//
// After an accepted start it waits LAT enabled cycles, then shifts in
// DEPTH result words, one per enabled cycle, into a register array that
// the host side reads back by absolute index.
//
// Ports:
//   clk       - clock, all state updates on the rising edge
//   rst       - synchronous active-high reset, overrides every other input
//   enable    - global advance; low freezes FSM, counters and writes
//   start     - begin a capture run (IDLE or DONE only, enable=1)
//   din       - result word from the array output
//   idx       - absolute read index
//   dout      - registered read data, 1-cycle latency, 0 when idx >= DEPTH
//   busy      - high in WAIT and CAPTURE
//   done      - high in DONE; contents stable until the next start
//   state_dbg - current FSM state, for observation only
//
// Handshake: there is no ready/ack. A start is accepted on an edge with
// enable=1 while the FSM is in IDLE or DONE; in WAIT or CAPTURE it is
// dropped. din is a free-running stream and is sampled on the enabled
// edges E0+LAT+1+k (k = 0..DEPTH-1), E0 being the accepting edge;
// edges with enable=0 are not counted.
module y_reg
  import mult_pkg::*;
#(
  parameter int WIDTH = PROD_W,
  parameter int DEPTH = MAX_STAGES,
  parameter int LAT   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic [IDX_W-1:0] idx,
  output logic [WIDTH-1:0] dout,
  output logic             busy,
  output logic             done,
  output y_state_t         state_dbg
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

  // Last latency count before capture starts; unused when LAT == 0.
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'((LAT > 0) ? LAT - 1 : 0);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  y_state_t         state;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] lat_cnt;
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      lat_cnt <= '0;
      dout    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      // Read port runs every cycle regardless of enable/state. Because
      // mem is updated with non-blocking assignments, a read of the slot
      // being written this edge returns the old contents.
      if (int'(idx) < DEPTH) begin
        dout <= mem[idx[PTR_W-1:0]];
      end else begin
        dout <= '0;
      end

      if (enable) begin
        case (state)
          IDLE, DONE: begin
            if (start) begin
              lat_cnt <= '0;
              wr_ptr  <= '0;
              state   <= (LAT > 0) ? WAIT : CAPTURE;
            end
          end

          WAIT: begin
            if (lat_cnt == LAT_LAST) begin
              wr_ptr <= '0;
              state  <= CAPTURE;
            end else begin
              lat_cnt <= lat_cnt + CNT_W'(1);
            end
          end

          CAPTURE: begin
            mem[wr_ptr] <= din;
            if (wr_ptr == PTR_LAST) begin
              wr_ptr <= '0;
              state  <= DONE;
            end else begin
              wr_ptr <= wr_ptr + PTR_W'(1);
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

  // Decodes of the state register; they follow the transitioning edge.
  assign busy      = (state == WAIT) || (state == CAPTURE);
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule : y_reg
